// File: rtl/norm_shift_exp_adjust.sv
// Post-add/subtract normalization for the FPU add/sub path.
// Takes the raw significand magnitude, the LZA left-shift amount and the
// pre-normalization exponent. It does a carry right-shift or an LZA left
// shift, then fixes a one-bit LZA miss in either direction, and then adjusts
// the exponent.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_i         capture inputs (IDLE only)
//   ack_i           result consumed (DONE only)
//   Sgf_i           raw magnitude, [SWR-1] carry, [SWR-2] normalized lead-one
//   Shift_Value_i   LZA left-shift amount
//   Exp_i           biased exponent before normalization
//   Sgf_o, Exp_o    normalized significand / adjusted exponent
//   sticky_o        bit lost by the carry right-shift
//   zero_o, overflow_o, underflow_o   mutually exclusive result flags
//   busy_o, ready_o FSM not IDLE / FSM in DONE
module norm_shift_exp_adjust #(
  parameter int SWR = 55,
  parameter int EW  = 11
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic           ack_i,
  input  logic [SWR-1:0] Sgf_i,
  input  logic [EW-1:0]  Shift_Value_i,
  input  logic [EW-1:0]  Exp_i,
  output logic [SWR-1:0] Sgf_o,
  output logic [EW-1:0]  Exp_o,
  output logic           sticky_o,
  output logic           zero_o,
  output logic           overflow_o,
  output logic           underflow_o,
  output logic           busy_o,
  output logic           ready_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, CORR, DONE} state_t;

  // Exponent math is EW+2 bits signed: one bit for the carry increment,
  // one for the sign after subtracting a large shift.
  localparam logic signed [EW+1:0] EMAX   = {2'b00, {EW{1'b1}}};
  localparam logic signed [EW+1:0] ONE    = {{(EW+1){1'b0}}, 1'b1};
  localparam logic [EW-1:0]        MAX_SH = EW'(SWR-1);

  state_t state_q, state_d;

  // captured operands
  logic [SWR-1:0] sgf_q;
  logic [EW-1:0]  shv_q, exp_q;

  // first-stage results
  logic [SWR-1:0]         s1_q, s1_d;
  logic signed [EW+1:0]   e1_q, e1_d;
  logic                   sticky1_q, carry_q, zero_q;

  // final-stage next values
  logic [SWR-1:0]         sgf_n, s2;
  logic [EW-1:0]          exp_n;
  logic signed [EW+1:0]   e2;
  logic                   sticky_n, zero_n, ovf_n, unf_n;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = SHIFT;
      SHIFT:   state_d = CORR;
      CORR:    state_d = DONE;
      DONE:    if (ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o  = (state_q != IDLE);
  assign ready_o = (state_q == DONE);

  // First shift: carry right-shift, or LZA-directed left shift.
  always_comb begin
    if (sgf_q[SWR-1]) begin
      s1_d = sgf_q >> 1;
      e1_d = signed'({2'b00, exp_q}) + ONE;
    end else begin
      s1_d = (shv_q > MAX_SH) ? '0 : (sgf_q << shv_q);
      e1_d = signed'({2'b00, exp_q}) - signed'({2'b00, shv_q});
    end
  end

  // Correction and flag resolution. The LZA may be off by one in either
  // direction. Overshoot (carry bit set) is checked before undershoot so that
  // at most one correction is applied.
  always_comb begin
    sgf_n    = '0;
    exp_n    = '0;
    sticky_n = 1'b0;
    zero_n   = 1'b0;
    ovf_n    = 1'b0;
    unf_n    = 1'b0;
    s2       = s1_q;
    e2       = e1_q;
    if (zero_q) begin
      zero_n = 1'b1;
    end else if (carry_q) begin
      if (e1_q >= EMAX) begin
        ovf_n = 1'b1;
        exp_n = '1;
      end else begin
        sgf_n    = s1_q;
        exp_n    = e1_q[EW-1:0];
        sticky_n = sticky1_q;
      end
    end else begin
      if (s1_q[SWR-1]) begin
        s2 = s1_q >> 1;
        e2 = e1_q + ONE;
      end else if (!s1_q[SWR-2] && (s1_q != '0)) begin
        s2 = s1_q << 1;
        e2 = e1_q - ONE;
      end
      // s1 == 0 here means the whole nonzero input was shifted out.
      if ((s1_q == '0) || e2[EW+1] || (e2 == '0)) begin
        unf_n = 1'b1;
      end else begin
        sgf_n = s2;
        exp_n = e2[EW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sgf_q       <= '0;
      shv_q       <= '0;
      exp_q       <= '0;
      s1_q        <= '0;
      e1_q        <= '0;
      sticky1_q   <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      Sgf_o       <= '0;
      Exp_o       <= '0;
      sticky_o    <= 1'b0;
      zero_o      <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_i) begin
        sgf_q <= Sgf_i;
        shv_q <= Shift_Value_i;
        exp_q <= Exp_i;
      end
      if (state_q == SHIFT) begin
        s1_q      <= s1_d;
        e1_q      <= e1_d;
        sticky1_q <= sgf_q[SWR-1] & sgf_q[0];
        carry_q   <= sgf_q[SWR-1];
        zero_q    <= (sgf_q == '0);
      end
      if (state_q == CORR) begin
        Sgf_o       <= sgf_n;
        Exp_o       <= exp_n;
        sticky_o    <= sticky_n;
        zero_o      <= zero_n;
        overflow_o  <= ovf_n;
        underflow_o <= unf_n;
      end
    end
  end

endmodule

// File: tb/tb_norm_shift_exp_adjust.sv
// Scoreboard bench for norm_shift_exp_adjust. The driver pushes hand-computed
// expected results. The monitor pops one on every rising ready_o and compares it.
module tb_norm_shift_exp_adjust;
  localparam int SWR = 55;
  localparam int EW  = 11;

  localparam logic [SWR-1:0] P40 = 55'h100_0000_0000;
  localparam logic [SWR-1:0] P53 = 55'h20_0000_0000_0000;
  localparam logic [SWR-1:0] P54 = 55'h40_0000_0000_0000;

  typedef struct {
    logic [SWR-1:0] sgf;
    logic [EW-1:0]  ex;
    logic           sticky, zero, ovf, unf;
  } exp_t;

  logic clk = 0, rst = 1, start_i = 0, ack_i = 0;
  logic [SWR-1:0] Sgf_i = '0;
  logic [EW-1:0]  Shift_Value_i = '0, Exp_i = '0;
  logic [SWR-1:0] Sgf_o;
  logic [EW-1:0]  Exp_o;
  logic sticky_o, zero_o, overflow_o, underflow_o, busy_o, ready_o;

  int compared = 0, mismatched = 0;
  exp_t q[$];
  logic ready_prev = 0;

  norm_shift_exp_adjust #(.SWR(SWR), .EW(EW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .ack_i(ack_i),
    .Sgf_i(Sgf_i), .Shift_Value_i(Shift_Value_i), .Exp_i(Exp_i),
    .Sgf_o(Sgf_o), .Exp_o(Exp_o), .sticky_o(sticky_o), .zero_o(zero_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o),
    .busy_o(busy_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic exp_t mk(input logic [SWR-1:0] s, input logic [EW-1:0] e,
                              input logic st, z, o, u);
    exp_t x;
    x.sgf = s; x.ex = e; x.sticky = st; x.zero = z; x.ovf = o; x.unf = u;
    return x;
  endfunction

  // monitor
  always @(negedge clk) begin
    if (ready_o && !ready_prev) begin
      if (q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_ready: got result with empty scoreboard");
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("sgf_o",       64'(Sgf_o),       64'(x.sgf));
        chk("exp_o",       64'(Exp_o),       64'(x.ex));
        chk("sticky_o",    64'(sticky_o),    64'(x.sticky));
        chk("zero_o",      64'(zero_o),      64'(x.zero));
        chk("overflow_o",  64'(overflow_o),  64'(x.ovf));
        chk("underflow_o", 64'(underflow_o), 64'(x.unf));
      end
    end
    ready_prev <= ready_o;
  end

  // One complete operation with latency and handshake checks.
  task automatic run_op(input logic [SWR-1:0] s, input logic [EW-1:0] sh,
                        input logic [EW-1:0] e, input exp_t x);
    q.push_back(x);
    @(negedge clk);
    Sgf_i = s; Shift_Value_i = sh; Exp_i = e; start_i = 1;
    @(negedge clk);            // edge 0 done
    start_i = 0;
    chk("busy_after_start", 64'(busy_o), 64'd1);
    chk("ready_edge0", 64'(ready_o), 64'd0);
    @(negedge clk);            // edge 1 done
    chk("ready_edge1", 64'(ready_o), 64'd0);
    @(negedge clk);            // edge 2 done
    chk("ready_edge2", 64'(ready_o), 64'd1);
    @(negedge clk);
    chk("ready_hold", 64'(ready_o), 64'd1);
    ack_i = 1;
    @(negedge clk);
    ack_i = 0;
    chk("ready_after_ack", 64'(ready_o), 64'd0);
    chk("busy_after_ack", 64'(busy_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_sgf",  64'(Sgf_o), 64'd0);
    chk("rst_exp",  64'(Exp_o), 64'd0);
    chk("rst_flags", 64'({sticky_o, zero_o, overflow_o, underflow_o}), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd0);

    // exact LZA
    run_op(P40, 11'd13, 11'd100, mk(P53, 11'd87, 0, 0, 0, 0));
    // LZA undershoot, one-bit left correction
    run_op(P40, 11'd12, 11'd100, mk(P53, 11'd87, 0, 0, 0, 0));
    // LZA overshoot, one-bit right correction
    run_op(P40, 11'd14, 11'd100, mk(P53, 11'd87, 0, 0, 0, 0));
    // carry with sticky
    run_op(P54 + 55'd1, 11'd0, 11'd100, mk(P53, 11'd101, 1, 0, 0, 0));
    // carry just below overflow: 2045 -> 2046
    run_op(P54, 11'd0, 11'd2045, mk(P53, 11'd2046, 0, 0, 0, 0));
    // carry overflow: 2046 -> 2047
    run_op(P54 + 55'd1, 11'd0, 11'd2046, mk('0, 11'd2047, 0, 0, 1, 0));
    // underflow: 5-13 < 0
    run_op(P40, 11'd13, 11'd5, mk('0, 11'd0, 0, 0, 0, 1));
    // underflow boundary: E exactly 0, and E exactly 1
    run_op(P40, 11'd13, 11'd13, mk('0, 11'd0, 0, 0, 0, 1));
    run_op(P40, 11'd13, 11'd14, mk(P53, 11'd1, 0, 0, 0, 0));
    // shift past the datapath: everything shifted out
    run_op(55'd1, 11'd60, 11'd100, mk('0, 11'd0, 0, 0, 0, 1));
    // zero input, shift ignored
    run_op('0, 11'd60, 11'd100, mk('0, 11'd0, 0, 1, 0, 0));
    // exact normalized input, no shift: 2^53 with exp 7
    run_op(P53, 11'd0, 11'd7, mk(P53, 11'd7, 0, 0, 0, 0));

    // Handshake: start held high throughout; only one capture.
    q.push_back(mk(P53, 11'd87, 0, 0, 0, 0));
    @(negedge clk);
    Sgf_i = P40; Shift_Value_i = 11'd13; Exp_i = 11'd100; start_i = 1;
    repeat (3) @(negedge clk);
    chk("hs_ready", 64'(ready_o), 64'd1);
    Sgf_i = P54 + 55'd1; Shift_Value_i = 11'd0; Exp_i = 11'd200;  // next op B
    repeat (2) @(negedge clk);
    chk("hs_no_recapture", 64'(ready_o), 64'd1);
    chk("hs_sgf_stable", 64'(Sgf_o), 64'(P53));
    q.push_back(mk(P53, 11'd201, 1, 0, 0, 0));
    ack_i = 1;                 // ack with start high: back to IDLE only
    @(negedge clk);
    ack_i = 0;
    chk("hs_ack_idle", 64'(busy_o), 64'd0);
    chk("hs_hold_in_idle", 64'(Exp_o), 64'd87);
    @(negedge clk);            // start still high: B captured here
    start_i = 0;
    chk("hs_second_start", 64'(busy_o), 64'd1);
    repeat (2) @(negedge clk);
    chk("hs_second_ready", 64'(ready_o), 64'd1);
    ack_i = 1;
    @(negedge clk);
    ack_i = 0;

    // Reset while in SHIFT: aborted, no result expected.
    @(negedge clk);
    Sgf_i = P40; Shift_Value_i = 11'd13; Exp_i = 11'd50; start_i = 1;
    @(negedge clk);            // now SHIFT
    start_i = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_ready", 64'(ready_o), 64'd0);
    chk("abort_sgf", 64'(Sgf_o), 64'd0);
    chk("abort_exp", 64'(Exp_o), 64'd0);
    chk("abort_flags", 64'({sticky_o, zero_o, overflow_o, underflow_o}), 64'd0);
    repeat (4) @(negedge clk);
    chk("abort_no_ready", 64'(ready_o), 64'd0);
    run_op(P40, 11'd13, 11'd50, mk(P53, 11'd37, 0, 0, 0, 0));

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/norm_shift_exp_adjust.md
Name: norm_shift_exp_adjust

Overview:
- Post-add/subtract normalization stage of the FPU add/subtract path. Sits directly downstream of the leading-zero anticipator and consumes its registered shift value, the raw significand magnitude and the pre-normalization exponent.
- Performs a carry right-shift or an LZA-directed left shift. Then corrects the one-bit LZA undershoot and adjusts the exponent.
- Flags zero, overflow and underflow. A start/ready/ack handshake connects it to the add/subtract control FSM.

Parameters:
- SWR, 55, significand datapath width including carry bit (26 for single precision).
- EW, 11, exponent width (8 for single precision).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start_i  in  1  capture inputs; honoured only in IDLE.
- ack_i  in  1  result consumed; honoured only in DONE.
- Sgf_i  in  SWR  raw magnitude; bit SWR-1 is the carry position, bit SWR-2 is the normalized leading-one position.
- Shift_Value_i  in  EW  left-shift amount from the LZA.
- Exp_i  in  EW  biased exponent before normalization.
- Sgf_o  out  SWR  normalized significand, leading one at bit SWR-2.
- Exp_o  out  EW  adjusted biased exponent.
- sticky_o  out  1  bit lost by the carry right-shift.
- zero_o  out  1  result is exactly zero.
- overflow_o  out  1  exponent overflow; result is infinity.
- underflow_o  out  1  exponent underflow; result is flushed to zero.
- busy_o  out  1  state is not IDLE.
- ready_o  out  1  state is DONE.

Behaviour:
- Reset: on rst high at a clk edge, state becomes IDLE and every output register clears to 0. This includes Sgf_o, Exp_o, sticky_o and all flags. rst has priority over every other input.
- FSM has four states:
  - IDLE: on start_i, capture Sgf_i, Shift_Value_i and Exp_i; go to SHIFT. Otherwise stay.
  - SHIFT: register the first shift result and the intermediate exponent; go to CORR.
  - CORR: apply correction, update all outputs; go to DONE.
  - DONE: hold outputs; ack_i sends the FSM to IDLE.
- Latency:
  - start_i is sampled at edge 0.
  - Outputs update at edge 2.
  - ready_o is high from edge 2 until the edge at which ack_i is sampled.
  - Minimum start-to-start spacing is 4 cycles.
- Signals ignored outside their state:
  - start_i is ignored outside IDLE.
  - ack_i is ignored outside DONE.
  - In DONE, start_i together with ack_i returns the FSM to IDLE only. Inputs are not captured.
- Output hold: outputs hold their last values in IDLE. They change only at the CORR edge.
- Internal arithmetic: exponent math uses EW+2-bit signed values. E1 is the intermediate exponent.
- Zero case: captured Sgf equals 0. Then zero_o=1, Sgf_o=0, Exp_o=0, and the other flags are 0. Shift_Value is ignored.
- Carry case: Sgf[SWR-1]=1.
  - Sgf_o = Sgf>>1, sticky_o = Sgf[0], E1 = Exp+1.
  - No correction is applied.
  - If E1 >= 2^EW-1: overflow_o=1, Exp_o = all ones, Sgf_o=0.
- Left case: otherwise.
  - S1 = Sgf<<Shift_Value, zeros shifted in. If Shift_Value > SWR-1, S1=0.
  - E1 = Exp - Shift_Value.
  - Correction: if S1[SWR-2]=0 and S1!=0, shift left one more and decrement E1. If S1[SWR-1]=1 (LZA overshoot), shift right by one and increment E1.
  - Exactly one correction is applied at most.
  - sticky_o=0 in the left case.
- Underflow: the final E <= 0 (signed), or S1=0 while the input was nonzero. Then underflow_o=1, Exp_o=0, Sgf_o=0.
- Flag exclusivity: at most one of zero_o, overflow_o and underflow_o is set per operation.
- Reset during operation: returns to IDLE with outputs cleared. No ready_o pulse is produced for the aborted operation.

Test Plan:
1. Exact LZA, SWR=55, EW=11. Sgf_i=2^40, Shift=13, Exp=100 -> Sgf_o=2^53, Exp_o=87, all flags 0; ready_o high at edge 2.
2. LZA undershoot. Sgf_i=2^40, Shift=12, Exp=100 -> correction fires; Sgf_o=2^53, Exp_o=87.
3. Carry, with the overflow boundary.
   - Sgf_i=2^54+1, Exp=100 -> Sgf_o=2^53, sticky_o=1, Exp_o=101.
   - Same Sgf_i with Exp=2046 -> overflow_o=1, Exp_o=2047, Sgf_o=0.
4. Underflow and zero.
   - Sgf_i=2^40, Shift=13, Exp=5 -> underflow_o=1, Exp_o=0, Sgf_o=0.
   - Sgf_i=0, Shift=60 -> zero_o=1, all other outputs 0.
5. Handshake.
   - start_i held high through DONE -> exactly one capture.
   - ready_o held high until ack_i; ack_i with start_i in DONE -> IDLE, no capture.
   - A second start accepted one cycle later -> new result.
6. Reset mid-operation. rst asserted in SHIFT -> next cycle state IDLE, busy_o=0, all outputs 0, no ready_o; a subsequent operation completes normally.
